// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds uart_top's transmitter one frame at a time. A byte leaves the FIFO only after donetx confirms its frame.
// Optional build macro UART_TX_FIFO_OVF_CNT_EN adds a saturating dropped-write counter output (ovf_cnt).
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = CLK_FREQ / BAUD_RATE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 dintx,
  output logic                       newd,
  input  logic                       donetx,
`ifdef UART_TX_FIFO_OVF_CNT_EN
  output logic [15:0]                ovf_cnt,
`endif
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    dintx_q;
  logic          ovf_q;
  logic          done_q;
  logic [GW-1:0] gap_q, gap_d;
  state_e        state_q, state_d;

  logic push, drop, pop, load_head, done_rise;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign dintx     = dintx_q;
  assign ovf       = ovf_q;
  assign done_rise = donetx & ~done_q;

  // full is the pre-cycle value, so a write while full is dropped even if a pop lands this cycle
  assign push = wr_en & ~full;
  assign drop = wr_en & full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dintx_q  <= 8'h00;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= donetx;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end
      if (load_head) begin
        dintx_q <= mem_q[rd_ptr_q];
      end
    end
  end

`ifdef UART_TX_FIFO_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= 16'h0000;
    end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (done_rise) begin
          state_d = S_GAP;
          gap_d   = GW'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The head stays in the FIFO for the whole frame; it is popped only when the frame completes
  always_comb begin
    newd      = 1'b0;
    load_head = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: load_head = ~empty;
      S_SEND: begin
        newd = 1'b1;
        pop  = done_rise;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table-driven fill/overflow vectors, a behavioural transmitter
// with a byte scoreboard, and hand-written sequences for pop/write collisions and mid-frame reset.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int GAP   = 1000000 / 9600;
  localparam int FRAME = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, newd, ovf;
  logic [4:0] count;
  logic [7:0] dintx;
  logic       donetx, donetx_m, donetx_h;
`ifdef UART_TX_FIFO_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  assign donetx = donetx_m | donetx_h;

  uart_tx_fifo #(
    .CLK_FREQ(1000000), .BAUD_RATE(9600), .DEPTH(DEPTH), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .dintx(dintx), .newd(newd),
    .donetx(donetx),
`ifdef UART_TX_FIFO_OVF_CNT_EN
    .ovf_cnt(ovf_cnt),
`endif
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q[$];
  bit tx_en = 1'b0;
  bit gap_valid = 1'b0;
  int fall_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    if (q.size() < DEPTH) q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_left"}, q.size(), 0);
    repeat (GAP + 8) @(negedge clk);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_count"}, count, 0);
  endtask

  // Behavioural transmitter: checks each frame against the scoreboard, holds donetx high for 3 cycles
  initial begin
    logic [7:0] cap;
    logic held;
    donetx_m = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en && newd === 1'b1 && !rst) begin
        if (gap_valid) chk("gap_newd_rise", cyc - fall_cyc, GAP + 1);
        gap_valid = 1'b0;
        cap = dintx;
        if (q.size() == 0) chk("frame_unexpected", 1, 0);
        else chk("frame_byte", cap, q[0]);
        held = 1'b1;
        repeat (FRAME) begin
          @(negedge clk);
          if (!(newd === 1'b1 && dintx === cap)) held = 1'b0;
        end
        chk("frame_hold", held, 1'b1);
        donetx_m = 1'b1;
        @(negedge clk);
        chk("newd_fall", newd, 1'b0);
        if (q.size() != 0) void'(q.pop_front());
        chk("pop_count", count, q.size());
        fall_cyc = cyc;
        gap_valid = (q.size() != 0);
        repeat (2) @(negedge clk);
        donetx_m = 1'b0;
      end
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] d;
    int         cnt;
    logic       full;
    logic       empty;
    logic       newd;
    logic       ovf;
    logic [7:0] dintx;
  } vec_t;

  vec_t tv[19];

  initial begin
    tv[0] = '{1'b1, 8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[1] = '{1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    for (int i = 2; i <= 16; i++)
      tv[i] = '{1'b1, 8'(i), i, (i == 16), 1'b0, 1'b1, 1'b0, 8'hA5};
    tv[17] = '{1'b1, 8'hFF, 16, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    tv[18] = '{1'b1, 8'hFF, 16, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; donetx_h = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_newd", newd, 1'b0);
    chk("rst_dintx", dintx, 8'h00);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte, fill to DEPTH and two dropped writes, transmitter idle
    for (int i = 0; i < 19; i++) begin
      wr_en = tv[i].wr;
      wr_data = tv[i].d;
      if (tv[i].wr && q.size() < DEPTH) q.push_back(tv[i].d);
      @(negedge clk);
      chk($sformatf("vec%0d_count", i), count, tv[i].cnt);
      chk($sformatf("vec%0d_full", i), full, tv[i].full);
      chk($sformatf("vec%0d_empty", i), empty, tv[i].empty);
      chk($sformatf("vec%0d_newd", i), newd, tv[i].newd);
      chk($sformatf("vec%0d_ovf", i), ovf, tv[i].ovf);
      chk($sformatf("vec%0d_dintx", i), dintx, tv[i].dintx);
    end
    wr_en = 1'b0;
`ifdef UART_TX_FIFO_OVF_CNT_EN
    chk("ovf_cnt", ovf_cnt, 16'd2);
`endif
    tx_en = 1'b1;
    drain("fill");
    chk("fill_ovf_sticky", ovf, 1'b1);

    // Burst of 16 consecutive writes while the transmitter runs
    for (int i = 1; i <= 16; i++) put(8'(i));
    chk("burst_full", full, 1'b1);
    chk("burst_count", count, 16);
    drain("burst");

    // Write lands in the same cycle as the donetx rise
    tx_en = 1'b0;
    put(8'h31); put(8'h32); put(8'h33);
    repeat (2) @(negedge clk);
    chk("sim_newd", newd, 1'b1);
    chk("sim_dintx", dintx, 8'h31);
    chk("sim_count_pre", count, 3);
    donetx_h = 1'b1;
    wr_en = 1'b1; wr_data = 8'h34; q.push_back(8'h34);
    @(negedge clk);
    wr_en = 1'b0;
    chk("sim_count_post", count, 3);
    chk("sim_newd_fall", newd, 1'b0);
    void'(q.pop_front());
    repeat (3) @(negedge clk);
    donetx_h = 1'b0;
    tx_en = 1'b1;
    drain("sim");

    // Reset while a frame is in flight
    tx_en = 1'b0;
    put(8'h41); put(8'h42); put(8'h43); put(8'h44);
    repeat (2) @(negedge clk);
    chk("mid_newd_pre", newd, 1'b1);
    chk("mid_count_pre", count, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_newd", newd, 1'b0);
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1'b1);
    chk("mid_dintx", dintx, 8'h00);
    chk("mid_ovf", ovf, 1'b0);
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    put(8'h3C);
    tx_en = 1'b1;
    drain("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
